// File: rtl/dual_deque_arbiter_pkg.sv
// Shared encodings for the dual_deque request arbiter: operation codes,
// requester indices, FSM state type and the status rejection rule.
package dual_deque_arbiter_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A pop from an empty deque or a push to a full one is refused.
    function automatic logic op_rejected(input logic pop, input logic empty, input logic full);
        return (pop == OP_POP) ? empty : full;
    endfunction

endpackage

// File: rtl/dual_deque_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last requester served
// and only advances when the owning FSM reports a completed operation.
module rr_arbiter2
    import dual_deque_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    input  logic granted,
    output logic grant_valid,
    output logic grant
);

    logic last_grant;

    // Reset as if B was served last so A has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_B;
        end else if (update) begin
            last_grant <= granted;
        end
    end

    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant = ~last_grant;
        end else if (req_b) begin
            grant = REQ_B;
        end else begin
            grant = REQ_A;
        end
    end

endmodule

// File: rtl/dual_deque_arbiter.sv
// Two-requester front end for dual_deque: round-robin arbitration, one push/pop
// strobe per accepted command, and registered ack/err/rdata back to the winner.
module dual_deque_arbiter
    import dual_deque_arbiter_pkg::*;
#(
    parameter int unsigned POP_LATENCY = 1,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic                 a_pop,
    input  logic                 a_deque,
    input  logic                 a_end,
    input  logic [7:0]           a_wdata,
    output logic                 a_ack,
    output logic                 a_err,
    output logic [7:0]           a_rdata,
    input  logic                 b_req,
    input  logic                 b_pop,
    input  logic                 b_deque,
    input  logic                 b_end,
    input  logic [7:0]           b_wdata,
    output logic                 b_ack,
    output logic                 b_err,
    output logic [7:0]           b_rdata,
    output logic                 dq_deque_select,
    output logic                 dq_end_select,
    output logic                 dq_push,
    output logic                 dq_pop,
    output logic [7:0]           dq_data_in,
    input  logic [7:0]           dq_data_out,
    input  logic                 d0_empty,
    input  logic                 d0_full,
    input  logic                 d1_empty,
    input  logic                 d1_full,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] WAIT_LAST = 2'((POP_LATENCY >= 2) ? POP_LATENCY - 2 : 0);

    state_t     state;
    logic       winner;
    logic       op_pop;
    logic [1:0] wait_cnt;

    logic       grant_valid;
    logic       grant;
    logic       sel_pop;
    logic       sel_deque;
    logic       sel_end;
    logic [7:0] sel_wdata;
    logic       sel_reject;
    logic       reject_now;
    logic       finish_ok;
    logic       capture;
    logic       ack_now;
    logic       ack_who;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a       (a_req),
        .req_b       (b_req),
        .update      (state == ST_DONE),
        .granted     (winner),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        sel_pop    = (grant == REQ_B) ? b_pop   : a_pop;
        sel_deque  = (grant == REQ_B) ? b_deque : a_deque;
        sel_end    = (grant == REQ_B) ? b_end   : a_end;
        sel_wdata  = (grant == REQ_B) ? b_wdata : a_wdata;
        sel_reject = sel_deque ? op_rejected(sel_pop, d1_empty, d1_full)
                               : op_rejected(sel_pop, d0_empty, d0_full);
        reject_now = (state == ST_IDLE) && grant_valid && sel_reject;
        // Successful completion is the edge that enters DONE; pops sample data there.
        finish_ok  = ((state == ST_ISSUE) && ((op_pop == OP_PUSH) || (POP_LATENCY == 1))) ||
                     ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));
        capture    = finish_ok && (op_pop == OP_POP);
        ack_now    = finish_ok || reject_now;
        ack_who    = reject_now ? grant : winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            winner          <= REQ_A;
            op_pop          <= OP_PUSH;
            wait_cnt        <= '0;
            a_ack           <= 1'b0;
            a_err           <= 1'b0;
            a_rdata         <= '0;
            b_ack           <= 1'b0;
            b_err           <= 1'b0;
            b_rdata         <= '0;
            dq_deque_select <= 1'b0;
            dq_end_select   <= 1'b0;
            dq_push         <= 1'b0;
            dq_pop          <= 1'b0;
            dq_data_in      <= '0;
            err_count       <= '0;
        end else begin
            a_ack   <= ack_now && (ack_who == REQ_A);
            b_ack   <= ack_now && (ack_who == REQ_B);
            a_err   <= reject_now && (grant == REQ_A);
            b_err   <= reject_now && (grant == REQ_B);
            dq_push <= 1'b0;
            dq_pop  <= 1'b0;

            if (capture && (winner == REQ_A)) a_rdata <= dq_data_out;
            if (capture && (winner == REQ_B)) b_rdata <= dq_data_out;
            if (reject_now && (err_count != '1)) err_count <= err_count + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        winner <= grant;
                        op_pop <= sel_pop;
                        if (sel_reject) begin
                            state <= ST_DONE;
                        end else begin
                            state           <= ST_ISSUE;
                            dq_deque_select <= sel_deque;
                            dq_end_select   <= sel_end;
                            dq_data_in      <= sel_wdata;
                            dq_push         <= (sel_pop == OP_PUSH);
                            dq_pop          <= (sel_pop == OP_POP);
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= finish_ok ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish_ok) state <= ST_DONE;
                    else           wait_cnt <= wait_cnt + 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
